regfile_scan: RTL and testbench
===============================

// Module: regfile_scan
// PURPOSE
//  Parametrised 1-write/2-read register file, successor of the Sprint3 RegisterFile.
//  - Generalised width/depth; optional hardwired zero register.
//  - Sequential bulk-clear engine with busy flag.
//  - Free-running scan port that walks every register for the HEX/LCD display path.
//  - Sits between the SW/KEY stimulus and the display decoders in the board top.
// PARAMETERS
//  DATA_W    8           register width in bits
//  ADDR_W    3           address width; DEPTH = 2**ADDR_W (localparam)
//  ZERO_REG  0           1: register 0 reads 0 and ignores writes
//  SCAN_DIV  25_000_000  clk cycles between scan steps (>=1)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  we3         in   1       write enable
//  wa3         in   ADDR_W  write address
//  wd3         in   DATA_W  write data
//  ra1         in   ADDR_W  read address, port 1
//  ra2         in   ADDR_W  read address, port 2
//  rd1         out  DATA_W  read data port 1, combinational
//  rd2         out  DATA_W  read data port 2, combinational
//  clr_req     in   1       pulse: start bulk clear
//  busy        out  1       high while the clear engine runs
//  scan_addr   out  ADDR_W  address of the last scanned register
//  scan_data   out  DATA_W  contents captured at scan_addr
//  scan_valid  out  1       one-cycle pulse per scan step
// BEHAVIOUR
//  Reset (async, any state):
//  - All registers = 0; FSM -> IDLE.
//  - busy=0, scan_addr=0, scan_data=0, scan_valid=0.
//  - Scan pointer and divider = 0.
//  Write:
//  - Occurs on the clk edge when we3=1, state=IDLE and clr_req=0.
//  - With ZERO_REG=1, a write to address 0 is discarded.
//  Read:
//  - rd1/rd2 = mem[ra1]/mem[ra2] combinationally.
//  - With ZERO_REG=1, address 0 reads 0.
//  - ra1==ra2 is legal; both ports return the same value.
//  FSM states: IDLE, CLEAR.
//  - IDLE -> CLEAR on clr_req=1. clr_req wins over a same-cycle we3; that write is dropped.
//  - CLEAR: clears mem[cnt] each cycle for cnt=0..DEPTH-1, exactly DEPTH cycles, then -> IDLE.
//  - busy=1 for exactly the DEPTH cycles spent in CLEAR.
//  - In CLEAR: we3 is ignored, clr_req is ignored (no restart), reads return current,
//    partially cleared contents.
//  - Reset during CLEAR aborts the clear; all registers are zero anyway.
//  Scan:
//  - The divider counts 0..SCAN_DIV-1 and wraps. The step fires on terminal count.
//  - On each step: scan_addr<=ptr, scan_data<=read(ptr) using the same ZERO_REG masking,
//    scan_valid<=1 for one cycle, ptr<=ptr+1 with wrap DEPTH-1 -> 0.
//  - First step reports register 0 at edge SCAN_DIV after reset release.
//  - Scan continues unchanged during CLEAR.
//  - A write and a scan of the same address on the same edge: scan captures the old value
//    unless bypass is enabled.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//  - Any read (rd1, rd2, scan capture) of address wa3 returns wd3 while an effective write
//    to wa3 is pending in that cycle (write-first).
//  - ZERO_REG masking still applies.
//  Not defined:
//  - Reads return the stored value; new data is visible the cycle after the write edge.
// TESTING (SCAN_DIV=4, DATA_W=8, ADDR_W=3)
//  1 Reset, write 8'hA5 to r3, read ra1=3 next cycle -> rd1=8'hA5, rd2(ra2=0)=8'h00.
//  2 ZERO_REG=1: write 8'hFF to r0 -> rd1(ra1=0)=0. Write r7=8'h3C -> rd2(ra2=7)=8'h3C.
//  3 Fill r0..r7, pulse clr_req:
//    - busy=1 for exactly 8 cycles; we3 in that window has no effect.
//    - All reads 0 afterwards.
//  4 clr_req with we3 (wa3=2, wd3=8'h11) on the same edge -> r2 remains 0 after the clear.
//  5 Scan from reset -> scan_valid pulses every 4 cycles.
//    - scan_addr sequence 0,1,...,7,0; scan_data matches the stored contents.
//  6 Write r4=8'h5A on the edge where ra1=4:
//    - with REGFILE_BYPASS_EN: rd1=8'h5A before the edge.
//    - without: rd1 still old.
//    - Also assert rst mid-CLEAR -> busy=0 immediately.

Source files
------------

// File: rtl/regfile_scan.sv
// regfile_scan: parametrised 1-write/2-read register file with a sequential
// bulk-clear engine and a free-running scan port for the display path.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined     -> write-first: reads of wa3 return wd3 while a write to wa3
//                  is taking effect this cycle (rd1, rd2 and scan capture)
//   not defined -> reads return the stored value; new data visible next cycle
//
// FSM states:
//   state | meaning
//   IDLE  | normal operation, writes accepted, clr_req starts a clear
//   CLEAR | zeroing mem[clr_cnt] each cycle for DEPTH cycles, busy=1

module regfile_scan #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int SCAN_DIV = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [ADDR_W-1:0]   clr_cnt_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_eff;
    logic                hit1;
    logic                hit2;
    logic                hit_scan;

    logic [DIV_W-1:0]    div_cnt;
    logic                scan_tick;
    logic [ADDR_W-1:0]   scan_ptr;
    logic [DATA_W-1:0]   scan_rd;

    // Common read path: zero-register masking has priority over bypass so
    // register 0 can never appear non-zero, even for one cycle.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wr_hit,
        input logic [DATA_W-1:0] wdata
    );
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return '0;
        end
        if (wr_hit) begin
            return wdata;
        end
        return stored;
    endfunction

    // A write lands only in IDLE and only if no clear is being requested on
    // the same edge; writes to a hardwired zero register are dropped here so
    // the bypass path never sees them either.
    always_comb begin
        wr_eff = we3 && (state == IDLE) && !clr_req;
        if ((ZERO_REG != 0) && (wa3 == '0)) begin
            wr_eff = 1'b0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward pending write data to any reader of the written address.
    always_comb begin
        hit1     = wr_eff && (ra1 == wa3);
        hit2     = wr_eff && (ra2 == wa3);
        hit_scan = wr_eff && (scan_ptr == wa3);
    end
`else
    // No forwarding: readers always see the stored value.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        hit_scan = 1'b0;
    end
`endif

    // Combinational read ports plus the value the scan step would capture.
    always_comb begin
        rd1     = read_sel(ra1, mem[ra1], hit1, wd3);
        rd2     = read_sel(ra2, mem[ra2], hit2, wd3);
        scan_rd = read_sel(scan_ptr, mem[scan_ptr], hit_scan, wd3);
    end

    // FSM state and clear-address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next state: CLEAR runs exactly DEPTH cycles and ignores clr_req.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    assign busy = (state == CLEAR);

    // Register array: reset clears everything, CLEAR zeroes one entry per
    // cycle, otherwise an effective write stores wd3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_eff) begin
            mem[wa3] <= wd3;
        end
    end

    assign scan_tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

    // Scan divider: counts 0..SCAN_DIV-1 and wraps; the wrap edge is a step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (scan_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Scan step: capture the pointed register, pulse valid, advance pointer.
    // Independent of the clear engine so the display keeps refreshing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_ptr   <= '0;
            scan_addr  <= '0;
            scan_data  <= '0;
            scan_valid <= 1'b0;
        end else begin
            scan_valid <= scan_tick;
            if (scan_tick) begin
                scan_addr <= scan_ptr;
                scan_data <= scan_rd;
                scan_ptr  <= scan_ptr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_scan.sv
// tb_regfile_scan: directed bench for regfile_scan (SCAN_DIV=4, 8x8).
// Instance u_dut has ZERO_REG=0, u_dut_z has ZERO_REG=1; both share clk/rst.

module tb_regfile_scan;

    localparam int DW = 8;
    localparam int AW = 3;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          a_we3, a_clr_req, a_busy, a_scan_valid;
    logic [AW-1:0] a_wa3, a_ra1, a_ra2, a_scan_addr;
    logic [DW-1:0] a_wd3, a_rd1, a_rd2, a_scan_data;

    logic          z_we3, z_clr_req, z_busy, z_scan_valid;
    logic [AW-1:0] z_wa3, z_ra1, z_ra2, z_scan_addr;
    logic [DW-1:0] z_wd3, z_rd1, z_rd2, z_scan_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] model [8];
    int            busy_cycles;

    always #5 clk = ~clk;

    regfile_scan #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .SCAN_DIV(4)) u_dut (
        .clk(clk), .rst(rst),
        .we3(a_we3), .wa3(a_wa3), .wd3(a_wd3),
        .ra1(a_ra1), .ra2(a_ra2), .rd1(a_rd1), .rd2(a_rd2),
        .clr_req(a_clr_req), .busy(a_busy),
        .scan_addr(a_scan_addr), .scan_data(a_scan_data), .scan_valid(a_scan_valid)
    );

    regfile_scan #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .SCAN_DIV(4)) u_dut_z (
        .clk(clk), .rst(rst),
        .we3(z_we3), .wa3(z_wa3), .wd3(z_wd3),
        .ra1(z_ra1), .ra2(z_ra2), .rd1(z_rd1), .rd2(z_rd2),
        .clr_req(z_clr_req), .busy(z_busy),
        .scan_addr(z_scan_addr), .scan_data(z_scan_data), .scan_valid(z_scan_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write one register of u_dut; starts and ends just after a negedge.
    task automatic wr_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a_we3 = 1'b1; a_wa3 = addr; a_wd3 = data;
        @(posedge clk);
        @(negedge clk);
        a_we3 = 1'b0;
    endtask

    task automatic wr_z(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        z_we3 = 1'b1; z_wa3 = addr; z_wd3 = data;
        @(posedge clk);
        @(negedge clk);
        z_we3 = 1'b0;
    endtask

    initial begin
        a_we3 = 0; a_wa3 = 0; a_wd3 = 0; a_ra1 = 0; a_ra2 = 0; a_clr_req = 0;
        z_we3 = 0; z_wa3 = 0; z_wd3 = 0; z_ra1 = 0; z_ra2 = 0; z_clr_req = 0;
        for (int i = 0; i < 8; i++) model[i] = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy",       a_busy,       0);
        chk("rst_scan_valid", a_scan_valid, 0);
        chk("rst_scan_addr",  a_scan_addr,  0);
        chk("rst_scan_data",  a_scan_data,  0);
        chk("rst_rd1",        a_rd1,        0);

        // Scan from reset release: steps at edges 4,8,..; r1..r7 written at edges 1..7.
        for (int e = 1; e <= 40; e++) begin
            if (e <= 7) begin
                a_we3 = 1'b1; a_wa3 = AW'(e); a_wd3 = DW'(8'h11 * e);
            end else begin
                a_we3 = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("scan_valid", a_scan_valid, ((e % 4) == 0) ? 1 : 0);
            if ((e % 4) == 0) begin
                chk("scan_addr", a_scan_addr, (e / 4 - 1) % 8);
                chk("scan_data", a_scan_data, model[(e / 4 - 1) % 8]);
            end
            if (e <= 7) model[e] = DW'(8'h11 * e);
        end
        a_we3 = 1'b0;

        // Basic write then read, port 2 on an unwritten register 0.
        wr_a(3'd3, 8'hA5);
        a_ra1 = 3'd3; a_ra2 = 3'd0;
        #1;
        chk("t1_rd1", a_rd1, 8'hA5);
        chk("t1_rd2", a_rd2, 8'h00);

        // Zero register behaviour on both builds of the parameter.
        wr_z(3'd0, 8'hFF);
        z_ra1 = 3'd0;
        #1;
        chk("t2_zero_rd1", z_rd1, 8'h00);
        wr_z(3'd7, 8'h3C);
        z_ra2 = 3'd7;
        #1;
        chk("t2_z_rd2", z_rd2, 8'h3C);
        wr_a(3'd0, 8'hFF);
        a_ra1 = 3'd0; a_ra2 = 3'd0;
        #1;
        chk("t2_nz_rd1", a_rd1, 8'hFF);
        chk("t2_same_rd2", a_rd2, 8'hFF);

        // Fill, then bulk clear with writes and a second clr_req during busy.
        for (int k = 0; k < 8; k++) wr_a(AW'(k), DW'(8'hA0 + k));
        a_ra1 = 3'd5; a_ra2 = 3'd6;
        #1;
        chk("t3_fill_rd1", a_rd1, 8'hA5);
        chk("t3_fill_rd2", a_rd2, 8'hA6);
        a_clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_clr_req = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!a_busy) break;
            busy_cycles++;
            a_we3 = 1'b1; a_wa3 = 3'd0; a_wd3 = 8'hFF;
            a_clr_req = (busy_cycles == 3);
            @(posedge clk);
            @(negedge clk);
        end
        a_we3 = 1'b0; a_clr_req = 1'b0;
        chk("t3_busy_cycles", busy_cycles, 8);
        for (int k = 0; k < 8; k++) begin
            a_ra1 = AW'(k); a_ra2 = AW'(7 - k);
            #1;
            chk("t3_clr_rd1", a_rd1, 8'h00);
            chk("t3_clr_rd2", a_rd2, 8'h00);
        end

        // clr_req beats a same-edge write; r2 keeps its old value until cleared.
        wr_a(3'd2, 8'h22);
        a_clr_req = 1'b1; a_we3 = 1'b1; a_wa3 = 3'd2; a_wd3 = 8'h11;
        @(posedge clk);
        @(negedge clk);
        a_clr_req = 1'b0; a_we3 = 1'b0; a_ra1 = 3'd2;
        #1;
        chk("t4_busy", a_busy, 1);
        chk("t4_r2_during", a_rd1, 8'h22);
        for (int c = 0; c < 20; c++) begin
            if (!a_busy) break;
            @(negedge clk);
            #1;
        end
        chk("t4_done", a_busy, 0);
        chk("t4_r2_after", a_rd1, 8'h00);

        // Same-edge write/read of r4: bypass shows new data before the edge.
        wr_a(3'd4, 8'h44);
        a_we3 = 1'b1; a_wa3 = 3'd4; a_wd3 = 8'h5A; a_ra1 = 3'd4;
        z_we3 = 1'b1; z_wa3 = 3'd0; z_wd3 = 8'h77; z_ra1 = 3'd0;
        #1;
        chk("t6_pre_edge", a_rd1, BYP ? 8'h5A : 8'h44);
        chk("t6_zero_byp", z_rd1, 8'h00);
        @(posedge clk);
        @(negedge clk);
        a_we3 = 1'b0; z_we3 = 1'b0;
        #1;
        chk("t6_post_edge", a_rd1, 8'h5A);

        // Reset in the middle of a clear drops busy immediately.
        a_clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_clr_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("t6_busy_mid", a_busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", a_busy, 0);
        chk("t6_rst_rd1", a_rd1, 8'h00);
        chk("t6_rst_scan_valid", a_scan_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
